// File: rtl/uart_alu_pkg.sv
// ============================================================================
// Module : uart_alu_pkg
// Brief  : Opcodes, status codes and FSM encoding for the UART ALU sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } alu_op_e;

  // Largest legal opcode byte; anything above is reported as ST_BADOP.
  localparam logic [7:0] OP_MAX = 8'h03;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADOP   = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_alu_accum.sv
// ============================================================================
// Module : uart_alu_accum
// Brief  : RES_W accumulator with load, op-select, enable and clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_alu_accum
  import uart_alu_pkg::*;
#(
  parameter int RES_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  alu_op_e          op,
  input  logic [RES_W-1:0] operand,
  output logic [RES_W-1:0] acc
);

  logic [RES_W-1:0] r_acc;
  logic [RES_W-1:0] w_next;

  always_comb begin
    w_next = r_acc;
    case (op)
      OP_ADD:  w_next = r_acc + operand;
      OP_SUB:  w_next = r_acc - operand;
      OP_AND:  w_next = r_acc & operand;
      OP_XOR:  w_next = r_acc ^ operand;
      default: w_next = r_acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= load ? operand : w_next;
    end
  end

  assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/uart_alu_sequencer.sv
// ============================================================================
// Module : uart_alu_sequencer
// Brief  : Byte-stream command engine: opcode + operands in, status + result out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_alu_sequencer
  import uart_alu_pkg::*;
#(
  parameter int OPERAND_BYTES  = 1,
  parameter int NUM_OPERANDS   = 2,
  parameter int TIMEOUT_CYCLES = 868000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy
);

  localparam int RES_BYTES = OPERAND_BYTES + 1;
  localparam int RES_W     = 8 * RES_BYTES;
  localparam int OP_W      = 8 * OPERAND_BYTES;
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_up;
  logic [7:0]       r_opcode;
  logic [7:0]       r_status;
  logic [1:0]       r_byte_cnt;
  logic [2:0]       r_op_cnt;
  logic [2:0]       r_tx_idx;
  logic [TMO_W-1:0] r_tmo;

  logic             w_rx_fire;
  logic             w_tx_fire;
  logic             w_collect_rx;
  logic             w_byte_last;
  logic             w_op_done;
  logic             w_last_op;
  logic             w_timeout;
  logic             w_tx_last;
  logic             w_acc_clr;
  logic [OP_W-1:0]  w_operand;
  logic [RES_W-1:0] w_acc;

  assign w_rx_fire    = s_axis_tvalid && s_axis_tready;
  assign w_tx_fire    = m_axis_tvalid && m_axis_tready;
  assign w_collect_rx = (r_state == COLLECT) && w_rx_fire;
  assign w_byte_last  = (r_byte_cnt == 2'(OPERAND_BYTES - 1));
  assign w_op_done    = w_collect_rx && w_byte_last;
  assign w_last_op    = (r_op_cnt == 3'(NUM_OPERANDS - 1));
  // An accepted byte wins over a timeout landing in the same cycle.
  assign w_timeout    = (r_state == COLLECT) && !w_rx_fire && (r_tmo == TMO_W'(TIMEOUT_CYCLES));
  assign w_tx_last    = (r_tx_idx == 3'(RES_BYTES));
  assign w_acc_clr    = w_timeout || ((r_state == RESP) && w_tx_fire && w_tx_last);

  // The operand completes with the byte currently on the bus, so only the
  // earlier bytes of the operand need storage.
  generate
    if (OPERAND_BYTES == 1) begin : g_opnd_single
      assign w_operand = s_axis_tdata;
    end else begin : g_opnd_multi
      logic [OP_W-9:0] r_part;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_part <= '0;
        end else if (w_collect_rx) begin
          r_part <= w_operand[OP_W-1:8];
        end
      end
      assign w_operand = {s_axis_tdata, r_part};
    end
  endgenerate

  uart_alu_accum #(
    .RES_W (RES_W)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_acc_clr),
    .en      (w_op_done),
    .load    (r_op_cnt == 3'd0),
    .op      (alu_op_e'(r_opcode[1:0])),
    .operand ({8'h00, w_operand}),
    .acc     (w_acc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    busy          = 1'b0;
    case (r_state)
      IDLE: begin
        s_axis_tready = r_up;
        if (w_rx_fire) w_state_nxt = COLLECT;
      end
      COLLECT: begin
        s_axis_tready = 1'b1;
        busy          = 1'b1;
        if ((w_op_done && w_last_op) || w_timeout) w_state_nxt = RESP;
      end
      RESP: begin
        m_axis_tvalid = 1'b1;
        busy          = 1'b1;
        if (r_tx_idx == 3'd0) begin
          m_axis_tdata = r_status;
        end else if (r_status == ST_OK) begin
          for (int i = 0; i < RES_BYTES; i++) begin
            if (r_tx_idx == 3'(i + 1)) m_axis_tdata = w_acc[8*i +: 8];
          end
        end
        if (w_tx_fire && w_tx_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_up       <= 1'b0;
      r_opcode   <= 8'h00;
      r_status   <= ST_OK;
      r_byte_cnt <= 2'd0;
      r_op_cnt   <= 3'd0;
      r_tx_idx   <= 3'd0;
      r_tmo      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_up    <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_rx_fire) begin
            r_opcode   <= s_axis_tdata;
            r_byte_cnt <= 2'd0;
            r_op_cnt   <= 3'd0;
            r_tx_idx   <= 3'd0;
            r_tmo      <= '0;
          end
        end
        COLLECT: begin
          if (w_rx_fire) begin
            r_tmo <= '0;
            if (w_byte_last) begin
              r_byte_cnt <= 2'd0;
              r_op_cnt   <= r_op_cnt + 3'd1;
              if (w_last_op) r_status <= (r_opcode > OP_MAX) ? ST_BADOP : ST_OK;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end else if (w_timeout) begin
            r_tmo    <= '0;
            r_status <= ST_TIMEOUT;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        RESP: begin
          if (w_tx_fire) r_tx_idx <= w_tx_last ? 3'd0 : r_tx_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_sequencer.sv
// ============================================================================
// Module : tb_uart_alu_sequencer
// Brief  : Scoreboard bench for two sequencer configurations (1x2 and 2x3 bytes).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_alu_sequencer;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata  [2];
  logic       s_tvalid [2];
  logic       s_tready [2];
  logic [7:0] m_tdata  [2];
  logic       m_tvalid [2];
  logic       m_tready [2];
  logic       busy     [2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  uart_alu_sequencer #(
    .OPERAND_BYTES (1), .NUM_OPERANDS (2), .TIMEOUT_CYCLES (TMO)
  ) u_dut0 (
    .clk (clk), .rst (rst),
    .s_axis_tdata (s_tdata[0]), .s_axis_tvalid (s_tvalid[0]), .s_axis_tready (s_tready[0]),
    .m_axis_tdata (m_tdata[0]), .m_axis_tvalid (m_tvalid[0]), .m_axis_tready (m_tready[0]),
    .busy (busy[0])
  );

  uart_alu_sequencer #(
    .OPERAND_BYTES (2), .NUM_OPERANDS (3), .TIMEOUT_CYCLES (TMO)
  ) u_dut1 (
    .clk (clk), .rst (rst),
    .s_axis_tdata (s_tdata[1]), .s_axis_tvalid (s_tvalid[1]), .s_axis_tready (s_tready[1]),
    .m_axis_tdata (m_tdata[1]), .m_axis_tvalid (m_tvalid[1]), .m_axis_tready (m_tready[1]),
    .busy (busy[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Sampled on the falling edge: a byte seen with tready high is taken on the next rise.
  always @(negedge clk) begin
    if (rst && m_tvalid[0]) begin
      check("rx_held0", s_tready[0], 0);
      check("busy_tx0", busy[0], 1);
      if (q0.size() == 0) check("spurious0", 1, 0);
      else if (m_tready[0]) check("tx0", m_tdata[0], q0.pop_front());
      else check("tx_hold0", m_tdata[0], q0[0]);
    end
  end

  always @(negedge clk) begin
    if (rst && m_tvalid[1]) begin
      check("rx_held1", s_tready[1], 0);
      if (q1.size() == 0) check("spurious1", 1, 0);
      else if (m_tready[1]) check("tx1", m_tdata[1], q1.pop_front());
      else check("tx_hold1", m_tdata[1], q1[0]);
    end
  end

  task automatic send(input int sel, input logic [7:0] b);
    int   n   = 0;
    logic acc = 1'b0;
    s_tdata[sel]  = b;
    s_tvalid[sel] = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = s_tready[sel];
      @(posedge clk);
      n++;
    end
    #1 s_tvalid[sel] = 1'b0;
    if (!acc) check("rx_accept", 0, 1);
  endtask

  // Reference model: reduce operands, push status + result, then drive the frame.
  task automatic frame(input int sel, input logic [7:0] opc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input int gap);
    int          ob = (sel != 0) ? 2 : 1;
    int          n  = (sel != 0) ? 3 : 2;
    logic [31:0] ops [3];
    logic [39:0] mask;
    logic [39:0] acc;
    logic [7:0]  st;
    ops[0] = a; ops[1] = b; ops[2] = c;
    mask = (40'd1 << (8 * (ob + 1))) - 40'd1;
    acc  = {8'h00, ops[0]};
    for (int i = 1; i < n; i++) begin
      case (opc)
        8'h00:   acc = acc + {8'h00, ops[i]};
        8'h01:   acc = acc - {8'h00, ops[i]};
        8'h02:   acc = acc & {8'h00, ops[i]};
        default: acc = acc ^ {8'h00, ops[i]};
      endcase
      acc = acc & mask;
    end
    st = (opc > 8'h03) ? 8'h01 : 8'h00;
    if (st != 8'h00) acc = '0;
    if (sel != 0) q1.push_back(st); else q0.push_back(st);
    for (int k = 0; k <= ob; k++) begin
      if (sel != 0) q1.push_back(acc[8*k +: 8]); else q0.push_back(acc[8*k +: 8]);
    end
    send(sel, opc);
    check("busy_op", busy[sel], 1);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < ob; k++) begin
        if (i == n - 1 && k == ob - 1 && gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        send(sel, ops[i][8*k +: 8]);
      end
    end
  endtask

  task automatic drain(input int sel);
    int n = 0;
    while (((sel != 0) ? q1.size() : q0.size()) != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", (n < 2000) ? 1 : 0, 1);
    check("busy_idle", busy[sel], 0);
  endtask

  task automatic reset_checks();
    check("rst_rdy", s_tready[0], 0);
    check("rst_vld", m_tvalid[0], 0);
    check("rst_data", m_tdata[0], 0);
    check("rst_busy", busy[0], 0);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    check("rdy_pre", s_tready[0], 0);
    @(posedge clk);
    #1;
    check("rdy_up", s_tready[0], 1);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tdata[i] = 8'h00; s_tvalid[i] = 1'b0; m_tready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    release_reset();

    frame(0, 8'h00, 8'hFF, 8'h02, 0, 0); drain(0);
    frame(0, 8'h01, 8'h05, 8'h07, 0, 0); drain(0);
    frame(0, 8'h07, 8'h11, 8'h22, 0, 0); drain(0);
    frame(0, 8'h02, 8'hF0, 8'h3C, 0, 0); drain(0);

    // Timeout: expected T+1 edges from the last accepted byte to tvalid.
    q0.push_back(8'h02); q0.push_back(8'h00); q0.push_back(8'h00);
    send(0, 8'h00);
    send(0, 8'h10);
    n = 0;
    while (!m_tvalid[0] && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tmo_latency", n, TMO + 1);
    drain(0);
    frame(0, 8'h03, 8'h0F, 8'hFF, 0, 0); drain(0);

    // Byte accepted exactly when the counter reaches the limit.
    frame(0, 8'h00, 8'h10, 8'h20, 0, TMO); drain(0);

    // Backpressure mid-response with the next frame already waiting on rx.
    fork
      begin
        frame(0, 8'h00, 8'h81, 8'h92, 0, 0);
        frame(0, 8'h03, 8'hA5, 8'h5A, 0, 0);
      end
      begin
        int w = 0;
        while (q0.size() != 5 && w < 500) begin
          @(posedge clk);
          #1;
          w++;
        end
        m_tready[0] = 1'b0;
        repeat (50) @(posedge clk);
        #1 m_tready[0] = 1'b1;
      end
    join
    drain(0);

    repeat (4) begin
      frame(0, 8'($urandom_range(0, 5)), 32'($urandom_range(0, 255)),
            32'($urandom_range(0, 255)), 0, 0);
      drain(0);
    end

    // Reset mid-response drops the rest of the reply.
    frame(0, 8'h00, 8'h33, 8'h44, 0, 0);
    n = 0;
    while (q0.size() > 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b0;
    #1;
    reset_checks();
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    frame(0, 8'h00, 8'h01, 8'h02, 0, 0); drain(0);

    frame(1, 8'h00, 32'hFFFF, 32'hFFFF, 32'h0002, 0); drain(1);
    frame(1, 8'h01, 32'h1234, 32'h2345, 32'h0001, 0); drain(1);
    frame(1, 8'h02, 32'hF0F0, 32'h3CC3, 32'hFFFF, 0); drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
